// File: rtl/id_ex_forward_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU codes, default widths and the
// per-instruction control bundle carried down the pipeline registers.
package id_ex_forward_stage_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int RA_W_DEF  = 5;

  localparam logic [2:0] ALU_AND = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADD = 3'd2;
  localparam logic [2:0] ALU_SUB = 3'd6;
  localparam logic [2:0] ALU_SLT = 3'd7;

  // Valid plus the four control bits; the same bundle is used by EX/MEM and MEM/WB.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

endpackage

// File: rtl/id_ex_forward_stage_fwd_mux.sv
// Operand forwarding mux: picks the newest in-flight value for one register.
module fwd_mux
  import id_ex_forward_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RA_W  = RA_W_DEF
) (
  input  logic [RA_W-1:0]  reg_addr,
  input  logic [WIDTH-1:0] reg_data,
  input  logic             exmem_reg_write,
  input  logic [RA_W-1:0]  exmem_rd,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic             memwb_reg_write,
  input  logic [RA_W-1:0]  memwb_rd,
  input  logic [WIDTH-1:0] memwb_result,
  output logic [WIDTH-1:0] fwd_data
);

  // EX/MEM is younger than MEM/WB, so it is checked first; r0 is never forwarded.
  always_comb begin
    fwd_data = reg_data;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == reg_addr)) begin
      fwd_data = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == reg_addr)) begin
      fwd_data = memwb_result;
    end
  end

endmodule

// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// operand forwarding into the ALU and a saturating bubble counter.
module id_ex_forward_stage
  import id_ex_forward_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int RA_W  = RA_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_alu_src,
  input  logic             id_reg_dst,
  input  logic [2:0]       id_alu_ctrl,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             id_mem_to_reg,
  input  logic             flush,
  input  logic             exmem_reg_write,
  input  logic [RA_W-1:0]  exmem_rd,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic             memwb_reg_write,
  input  logic [RA_W-1:0]  memwb_rd,
  input  logic [WIDTH-1:0] memwb_result,
  output logic             stall,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_ctrl,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [RA_W-1:0]  ex_dest,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_mem_to_reg,
  output logic [CNT_W-1:0] bubble_cnt
);

  ctrl_t            ctrl_d, ctrl_q;
  logic [WIDTH-1:0] rs_data_d, rs_data_q;
  logic [WIDTH-1:0] rt_data_d, rt_data_q;
  logic [WIDTH-1:0] imm_d, imm_q;
  logic [RA_W-1:0]  rs_d, rs_q;
  logic [RA_W-1:0]  rt_d, rt_q;
  logic [RA_W-1:0]  dest_d, dest_q;
  logic             alu_src_d, alu_src_q;
  logic [2:0]       alu_ctrl_d, alu_ctrl_q;
  logic [CNT_W-1:0] bubble_cnt_d, bubble_cnt_q;

  logic             hazard;
  logic             load_bubble;
  logic [WIDTH-1:0] fwd_a, fwd_b;

  // Load in EX whose destination is a source of the instruction in ID.
  always_comb begin
    hazard = ctrl_q.valid && ctrl_q.mem_read && (dest_q != '0) &&
             ((dest_q == id_rs) || (dest_q == id_rt)) && id_valid;
    load_bubble = flush || hazard;
    stall       = hazard && !flush;
  end

  // Next ID/EX contents: a zeroed bubble, or the decoded ID fields.
  always_comb begin
    ctrl_d     = '0;
    rs_data_d  = '0;
    rt_data_d  = '0;
    imm_d      = '0;
    rs_d       = '0;
    rt_d       = '0;
    dest_d     = '0;
    alu_src_d  = 1'b0;
    alu_ctrl_d = ALU_AND;
    if (!load_bubble) begin
      ctrl_d.valid      = id_valid;
      ctrl_d.reg_write  = id_reg_write;
      ctrl_d.mem_read   = id_mem_read;
      ctrl_d.mem_write  = id_mem_write;
      ctrl_d.mem_to_reg = id_mem_to_reg;
      rs_data_d         = id_rs_data;
      rt_data_d         = id_rt_data;
      imm_d             = id_imm;
      rs_d              = id_rs;
      rt_d              = id_rt;
      dest_d            = id_reg_dst ? id_rd : id_rt;
      alu_src_d         = id_alu_src;
      alu_ctrl_d        = id_alu_ctrl;
    end
    bubble_cnt_d = bubble_cnt_q;
    if (load_bubble && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  // ID/EX register and bubble counter; reset discards any held instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q       <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      dest_q       <= '0;
      alu_src_q    <= 1'b0;
      alu_ctrl_q   <= ALU_AND;
      bubble_cnt_q <= '0;
    end else begin
      ctrl_q       <= ctrl_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      dest_q       <= dest_d;
      alu_src_q    <= alu_src_d;
      alu_ctrl_q   <= alu_ctrl_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  fwd_mux #(.WIDTH(WIDTH), .RA_W(RA_W)) u_fwd_a (
    .reg_addr        (rs_q),
    .reg_data        (rs_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_a)
  );

  fwd_mux #(.WIDTH(WIDTH), .RA_W(RA_W)) u_fwd_b (
    .reg_addr        (rt_q),
    .reg_data        (rt_data_q),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .fwd_data        (fwd_b)
  );

  // EX-side outputs: operand muxes and control pass-through.
  always_comb begin
    alu_a         = fwd_a;
    alu_b         = alu_src_q ? imm_q : fwd_b;
    ex_store_data = fwd_b;
    alu_ctrl      = alu_ctrl_q;
    ex_dest       = dest_q;
    ex_valid      = ctrl_q.valid;
    ex_reg_write  = ctrl_q.reg_write;
    ex_mem_read   = ctrl_q.mem_read;
    ex_mem_write  = ctrl_q.mem_write;
    ex_mem_to_reg = ctrl_q.mem_to_reg;
    bubble_cnt    = bubble_cnt_q;
  end

endmodule

// File: tb/tb_id_ex_forward_stage.sv
// Directed bench for id_ex_forward_stage: a vector table of single-cycle
// transactions plus hand sequences for forwarding priority, async reset and
// counter saturation.
module tb_id_ex_forward_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_alu_src, id_reg_dst;
  logic [2:0]  id_alu_ctrl;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        stall;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [2:0]  alu_ctrl;
  logic [4:0]  ex_dest;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [15:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_forward_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst), .id_alu_ctrl(id_alu_ctrl),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall(stall), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .ex_store_data(ex_store_data), .ex_dest(ex_dest), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg),
    .bubble_cnt(bubble_cnt)
  );

  typedef struct packed {
    logic        id_valid;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  rs, rt, rd;
    logic        alu_src, reg_dst;
    logic [2:0]  ctrl;
    logic        rw, mr, mw, m2r, flush;
    logic        ex_rw;
    logic [4:0]  ex_rd;
    logic [31:0] ex_res;
    logic        wb_rw;
    logic [4:0]  wb_rd;
    logic [31:0] wb_res;
    logic        e_stall;
    logic [31:0] e_a, e_b, e_store;
    logic [2:0]  e_ctrl;
    logic [4:0]  e_dest;
    logic        e_valid, e_rw, e_mr, e_mw, e_m2r;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.id_valid; id_rs_data = v.rs_data; id_rt_data = v.rt_data; id_imm = v.imm;
    id_rs = v.rs; id_rt = v.rt; id_rd = v.rd;
    id_alu_src = v.alu_src; id_reg_dst = v.reg_dst; id_alu_ctrl = v.ctrl;
    id_reg_write = v.rw; id_mem_read = v.mr; id_mem_write = v.mw; id_mem_to_reg = v.m2r;
    flush = v.flush;
    exmem_reg_write = v.ex_rw; exmem_rd = v.ex_rd; exmem_result = v.ex_res;
    memwb_reg_write = v.wb_rw; memwb_rd = v.wb_rd; memwb_result = v.wb_res;
  endtask

  task automatic apply(input int idx);
    vec_t v;
    string t;
    v = vecs[idx];
    @(negedge clk);
    drive(v);
    #1;
    t = $sformatf("v%0d", idx);
    chk({t, ".stall"}, {31'd0, stall}, {31'd0, v.e_stall});
    @(posedge clk);
    #1;
    chk({t, ".alu_a"}, alu_a, v.e_a);
    chk({t, ".alu_b"}, alu_b, v.e_b);
    chk({t, ".store"}, ex_store_data, v.e_store);
    chk({t, ".alu_ctrl"}, {29'd0, alu_ctrl}, {29'd0, v.e_ctrl});
    chk({t, ".dest"}, {27'd0, ex_dest}, {27'd0, v.e_dest});
    chk({t, ".ctrl_bits"},
        {27'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
        {27'd0, v.e_valid, v.e_rw, v.e_mr, v.e_mw, v.e_m2r});
    chk({t, ".bubble_cnt"}, {16'd0, bubble_cnt}, {16'd0, v.e_cnt});
  endtask

  initial begin
    //           vld rs_data    rt_data   imm          rs rt rd  src dst ctl rw mr mw m2r fl  exrw exrd exres     wbrw wbrd wbres     stall a          b            store       ctl dst  v rw mr mw m2r cnt
    vecs[0]  = '{1, 32'h5,     32'h7,    32'h100,     1, 2, 3,  0,  1,  2,  1, 0, 0, 0,  0,  0,   0,   32'h0,    0,   0,   32'h0,    0,    32'h5,     32'h7,       32'h7,     2,  3,   1, 1, 0, 0, 0,  0};
    vecs[1]  = '{1, 32'h10,    32'h20,   32'hFFFFFFF0,1, 5, 9,  1,  0,  0,  1, 0, 0, 0,  0,  1,   5,   32'hAA,   0,   0,   32'h0,    0,    32'h10,    32'hFFFFFFF0,32'hAA,    0,  5,   1, 1, 0, 0, 0,  0};
    vecs[2]  = '{1, 32'h1000,  32'h33,   32'h8,       2, 4, 0,  1,  0,  2,  1, 1, 0, 1,  0,  1,   0,   32'h5555, 1,   2,   32'h2000, 0,    32'h2000,  32'h8,       32'h33,    2,  4,   1, 1, 1, 0, 1,  0};
    vecs[3]  = '{1, 32'h44,    32'h66,   32'h0,       4, 6, 7,  0,  1,  6,  1, 0, 0, 0,  0,  0,   0,   32'h0,    0,   0,   32'h0,    1,    32'h0,     32'h0,       32'h0,     0,  0,   0, 0, 0, 0, 0,  1};
    vecs[4]  = '{1, 32'h44,    32'h66,   32'h0,       4, 6, 7,  0,  1,  6,  1, 0, 0, 0,  0,  0,   0,   32'h0,    1,   4,   32'h99,   0,    32'h99,    32'h66,      32'h66,    6,  7,   1, 1, 0, 0, 0,  1};
    vecs[5]  = '{1, 32'h1000,  32'h33,   32'h8,       2, 4, 0,  1,  0,  2,  1, 1, 0, 1,  0,  0,   0,   32'h0,    0,   0,   32'h0,    0,    32'h1000,  32'h8,       32'h33,    2,  4,   1, 1, 1, 0, 1,  1};
    vecs[6]  = '{1, 32'h44,    32'h66,   32'h0,       3, 4, 7,  0,  1,  6,  1, 0, 0, 0,  1,  0,   0,   32'h0,    0,   0,   32'h0,    0,    32'h0,     32'h0,       32'h0,     0,  0,   0, 0, 0, 0, 0,  2};
    vecs[7]  = '{0, 32'h7,     32'h9,    32'h0,       4, 4, 8,  0,  1,  1,  1, 0, 1, 0,  0,  0,   0,   32'h0,    0,   0,   32'h0,    0,    32'h7,     32'h9,       32'h9,     1,  8,   0, 1, 0, 1, 0,  2};
    vecs[8]  = '{0, 32'hDEAD,  32'hBEEF, 32'h1,       1, 2, 3,  0,  1,  2,  1, 1, 1, 1,  1,  0,   0,   32'h0,    0,   0,   32'h0,    0,    32'h0,     32'h0,       32'h0,     0,  0,   0, 0, 0, 0, 0,  3};
    vecs[9]  = '{1, 32'h1,     32'h2,    32'h0,       3, 3, 10, 0,  1,  7,  1, 0, 0, 0,  0,  1,   3,   32'h11,   1,   3,   32'h22,   0,    32'h11,    32'h11,      32'h11,    7,  10,  1, 1, 0, 0, 0,  3};
    vecs[10] = '{1, 32'h50,    32'h0,    32'h4,       9, 0, 0,  1,  0,  2,  1, 1, 0, 1,  0,  0,   0,   32'h0,    0,   0,   32'h0,    0,    32'h50,    32'h4,       32'h0,     2,  0,   1, 1, 1, 0, 1,  3};
    vecs[11] = '{1, 32'h3,     32'h4,    32'h0,       0, 0, 11, 0,  1,  1,  1, 0, 0, 0,  0,  0,   0,   32'h0,    0,   0,   32'h0,    0,    32'h3,     32'h4,       32'h4,     1,  11,  1, 1, 0, 0, 0,  3};

    drive(vecs[0]);
    flush = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset.stall", {31'd0, stall}, 32'd0);
    chk("reset.ex_valid", {31'd0, ex_valid}, 32'd0);
    drive('0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      apply(i);
      if (i == 9) begin
        // EX holds rs=3 (data 1): EX/MEM beats MEM/WB, then MEM/WB alone, then none.
        @(negedge clk);
        exmem_reg_write = 1'b0;
        #1;
        chk("dfwd.memwb_only", alu_a, 32'h22);
        memwb_rd = 5'd0;
        #1;
        chk("dfwd.rd0_registered", alu_a, 32'h1);
      end
    end

    // Asynchronous reset mid-cycle with live, non-zero ID fields.
    @(posedge clk);
    #3;
    drive(vecs[0]);
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("areset.alu_a", alu_a, 32'h0);
    chk("areset.alu_b", alu_b, 32'h0);
    chk("areset.store", ex_store_data, 32'h0);
    chk("areset.alu_ctrl", {29'd0, alu_ctrl}, 32'd0);
    chk("areset.dest", {27'd0, ex_dest}, 32'd0);
    chk("areset.ctrl_bits",
        {27'd0, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}, 32'd0);
    chk("areset.bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
    chk("areset.stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply(0);

    // Saturation: flush held high for 0xFFFF+3 edges from a zero count.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    drive('0);
    flush = 1'b1;
    repeat (16'hFFFE) @(posedge clk);
    #1;
    chk("sat.below", {16'd0, bubble_cnt}, 32'h0000FFFE);
    @(posedge clk);
    #1;
    chk("sat.reach", {16'd0, bubble_cnt}, 32'h0000FFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("sat.hold", {16'd0, bubble_cnt}, 32'h0000FFFF);
    chk("sat.stall", {31'd0, stall}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_forward_stage.md
# id_ex_forward_stage

Pipeline stage directly upstream of the ALU: captures decoded instruction fields from the ID stage into the ID/EX register and resolves data hazards. It selects forwarded operands from EX/MEM and MEM/WB and drives the ALU's A, B and 3-bit control inputs. It detects load-use hazards, issues the stall to IF/ID and the PC, and inserts bubbles. It also keeps a saturating count of inserted bubbles for performance debug.

## Interface
- WIDTH, 32, datapath width
- RA_W, 5, register-address width
- CNT_W, 16, bubble-counter width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs_data, id_rt_data  in  WIDTH  register-file read data
- id_imm  in  WIDTH  sign-extended immediate
- id_rs, id_rt, id_rd  in  RA_W  register addresses
- id_alu_src  in  1  1 = B operand is the immediate
- id_reg_dst  in  1  1 = destination is rd, 0 = rt
- id_alu_ctrl  in  3  ALU code: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control bits
- flush  in  1  kill the instruction entering EX (branch taken)
- exmem_reg_write  in  1;  exmem_rd  in  RA_W;  exmem_result  in  WIDTH
- memwb_reg_write  in  1;  memwb_rd  in  RA_W;  memwb_result  in  WIDTH
- stall  out  1  hold the PC and IF/ID register
- alu_a, alu_b  out  WIDTH  ALU operands
- alu_ctrl  out  3  ALU control
- ex_store_data  out  WIDTH  forwarded rt value for stores
- ex_dest  out  RA_W  resolved destination register
- ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  EX control pass-through
- bubble_cnt  out  CNT_W  number of bubbles inserted

## Operation
- ID/EX register fields: rs/rt data, imm, rs, rt, dest, alu_src, alu_ctrl, valid, the four control bits.
- dest is resolved at capture: id_reg_dst ? id_rd : id_rt.
- Hazard condition: ex_valid & ex_mem_read & ex_dest≠0 & (ex_dest==id_rs | ex_dest==id_rt) & id_valid.
- stall = hazard & ~flush. Output is combinational.
- Each edge loads one of two things:
  - Bubble: when flush | hazard. valid, reg_write, mem_read, mem_write and mem_to_reg are cleared, and alu_ctrl is set to 0. Data fields are don't-care; they are loaded with 0.
  - Capture: otherwise, all id_* fields are loaded.
- Forwarding, applied separately for rs (→ fwd_a) and rt (→ fwd_b):
  - Source is EX/MEM if exmem_reg_write & exmem_rd≠0 & exmem_rd==reg.
  - Otherwise MEM/WB if memwb_reg_write & memwb_rd≠0 & memwb_rd==reg.
  - Otherwise the registered data.
  - EX/MEM always wins when both match.
- alu_a = fwd_a.
- alu_b = alu_src ? imm : fwd_b.
- ex_store_data = fwd_b.
- alu_ctrl = registered alu_ctrl.
- bubble_cnt increments on each edge that loads a bubble and saturates at all-ones.
- Register 0 is never forwarded and never triggers a hazard.

## Timing
- Reset (rst_n low, asynchronous) clears every register to 0. Resulting outputs:
  - ex_valid and all control outputs 0
  - alu_ctrl 0, ex_dest 0, bubble_cnt 0
  - alu_a 0, alu_b 0, ex_store_data 0 (absent matching forward inputs)
  - stall 0
- Reset mid-stall discards the held instruction. Upstream re-fetch is the front end's responsibility.
- Capture latency is 1 cycle: ID inputs at edge N appear on the EX outputs after edge N.
- Forwarding and the alu_a/alu_b/ex_store_data muxes are combinational on the same cycle as the live exmem_*/memwb_* inputs. There are no registered forward paths.
- A load-use hazard gives exactly one stall cycle:
  - Cycle N: stall=1 and a bubble is loaded.
  - Cycle N+1: the load has moved to MEM, so the hazard clears; the held ID instruction is captured and takes its operand from MEM/WB one cycle later via forwarding.
- flush with a simultaneous hazard loads a bubble, stall=0, and bubble_cnt increments once.
- flush with id_valid=0 still loads a bubble and counts it.
- id_valid=0 without flush is a plain capture of an invalid instruction. It is not counted.

## Structure
- Shared package holds:
  - ALU control constants: ALU_AND=0, ALU_OR=1, ALU_ADD=2, ALU_SUB=6, ALU_SLT=7
  - the WIDTH and RA_W defaults
  - a packed struct for the four control bits plus valid, reused by the EX/MEM and MEM/WB registers
- One sub-module: fwd_mux. It takes reg address, registered data, and both forward ports, and returns the forwarded value. It is instantiated twice (rs and rt).
- Hazard detection, the ID/EX register and the counter stay in the top level.

## Test plan
- Reset: assert rst_n=0 mid-cycle with id fields non-zero → all outputs 0 immediately; after release, the first edge captures id_* normally.
- ADD with no hazards: rs_data=5, rt_data=7, alu_ctrl=2, alu_src=0 → next cycle alu_a=5, alu_b=7, alu_ctrl=2, ex_valid=1, ex_dest=rd.
- Double forward: captured rs=3; drive exmem_rd=3 with exmem_result=0x11 and memwb_rd=3 with memwb_result=0x22 (reg_write=1 on both) → alu_a=0x11. Drop exmem_reg_write → alu_a=0x22. Set the forward rd to 0 → alu_a is the registered data.
- Load-use: lw writing r4 in EX, next instruction `sub` reading r4 in ID → stall=1 for one cycle, bubble loaded (ex_valid=0, alu_ctrl=0), bubble_cnt=1. Next edge captures sub; with memwb_rd=4 and memwb_result=0x99, alu_a=0x99.
- Flush during hazard: conditions as in the load-use case plus flush=1 → stall=0, bubble loaded, bubble_cnt increments by exactly 1.
- Counter saturation: force 0xFFFF+3 bubbles (flush held high) → bubble_cnt stays 0xFFFF, no wrap to 0.
